// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFObuffer drain-side reader.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 4;
  localparam int unsigned CNT_WIDTH_DEF  = 8;
  localparam int unsigned SKID_DEPTH     = 2;

  typedef logic [1:0] occ_t;

  // Words the skid buffer must still be able to absorb once this cycle's
  // pop has retired: buffered entries plus the word already requested.
  function automatic logic [2:0] committed_words(input occ_t occ,
                                                 input logic inflight,
                                                 input logic pop);
    return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry register skid buffer: strict FIFO order, head exposed as a
// registered data/valid pair.
module fifo_reader_skid
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic                  head_valid_o,
  output occ_t                  occ_o
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  occ_t                  occ_q, occ_d;
  logic                  valid_q, valid_d;
  logic                  pop_eff;
  logic                  full;

  assign pop_eff = pop_i & valid_q;
  assign full    = (occ_q == 2'(SKID_DEPTH));

  // Next-state for entries and occupancy; a simultaneous push and pop keeps
  // occupancy and shifts the second entry (or the new word) into the head.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push_i, pop_eff})
      2'b10: begin
        if (!full) begin
          if (occ_q == '0) begin
            head_d = push_data_i;
          end else begin
            tail_d = push_data_i;
          end
          occ_d = occ_q + 2'd1;
        end
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (full) begin
          head_d = tail_q;
          tail_d = push_data_i;
        end else begin
          head_d = push_data_i;
        end
      end
      default: begin
      end
    endcase
    valid_d = (occ_d != '0);
  end

  // Buffer registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      assert (!(push_i && !pop_eff && full));
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
    end
  end

  assign head_data_o  = head_q;
  assign head_valid_o = valid_q;
  assign occ_o        = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Drain-side controller for FIFObuffer: issues RD on available credit,
// captures returned words into a skid buffer and presents them valid/ready.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  EN,
  input  logic                  fifoEmpty,
  input  logic [DATA_WIDTH-1:0] fifoData,
  output logic                  fifoRd,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  rdCount
);

  logic                 pop;
  logic [2:0]           committed;
  occ_t                 occ;
  logic                 inflight_q, inflight_d;
  logic                 busy_q, busy_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign pop       = outValid & outReady;
  assign committed = committed_words(occ, inflight_q, pop);
  // Credit check counts the word already in flight so a full buffer plus a
  // returning word can never overrun, even with outReady low.
  assign fifoRd    = Rst & EN & ~fifoEmpty & (committed < 3'(SKID_DEPTH));

  fifo_reader_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i        (Clk),
    .rst_n_i      (Rst),
    .push_i       (inflight_q),
    .push_data_i  (fifoData),
    .pop_i        (pop),
    .head_data_o  (outData),
    .head_valid_o (outValid),
    .occ_o        (occ)
  );

  // Next-state for the in-flight flag, busy status and delivered counter.
  always_comb begin
    inflight_d = fifoRd;
    busy_d     = fifoRd | (committed != '0);
    cnt_d      = cnt_q + CNT_WIDTH'(pop);
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy    = busy_q;
  assign rdCount = cnt_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: a queue-based FIFO source, a
// word-level reference model checked every cycle, plus directed literals.
module tb_fifo_reader;
  localparam int unsigned DW = 4;
  localparam int unsigned CW = 8;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          EN = 1'b0;
  logic          fifoEmpty = 1'b1;
  logic          outReady = 1'b0;
  logic [DW-1:0] fifoData = '0;
  logic          fifoRd, outValid, busy;
  logic [DW-1:0] outData;
  logic [CW-1:0] rdCount;

  fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .Clk(Clk), .Rst(Rst), .EN(EN), .fifoEmpty(fifoEmpty), .fifoData(fifoData),
    .fifoRd(fifoRd), .outData(outData), .outValid(outValid), .outReady(outReady),
    .busy(busy), .rdCount(rdCount)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Source FIFO contents (head at index 0)
  logic [DW-1:0] src[$];

  // Reference model: each requested word becomes visible two cycles after
  // its request and leaves on a handshake.
  typedef struct { logic [DW-1:0] word; int avail; } exp_t;
  exp_t exp_q[$];
  int  cyc = 0;
  int  owed = 0;
  int  pops = 0;
  bit  armed = 0;
  bit  after_rst = 0;
  bit  m_valid, m_pop, m_rd;

  always @(negedge Clk) begin
    m_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    m_pop   = m_valid && outReady;
    m_rd    = Rst && EN && !fifoEmpty && ((owed - (m_pop ? 1 : 0)) < 2);
    if (armed) begin
      chk("cmp_fifoRd", fifoRd, m_rd);
      chk("cmp_outValid", outValid, m_valid);
      chk("cmp_busy", busy, owed != 0);
      chk("cmp_rdCount", rdCount, pops % 256);
      if (m_valid) chk("cmp_outData", outData, exp_q[0].word);
      else if (after_rst) chk("cmp_outData_rst", outData, 0);
    end
    if (!Rst) begin
      exp_q.delete();
      owed = 0;
      pops = 0;
      after_rst = 1;
      armed = 1;
    end else if (armed) begin
      after_rst = 0;
      if (m_pop) begin
        void'(exp_q.pop_front());
        pops++;
        owed--;
      end
      if (m_rd && src.size() > 0) begin
        exp_q.push_back('{word: src[0], avail: cyc + 2});
        owed++;
      end
    end
    cyc++;
  end

  bit rd_now;

  // One clock: the source FIFO answers a read with its head on the next cycle.
  task automatic step();
    @(negedge Clk);
    rd_now = fifoRd;
    @(posedge Clk);
    #1;
    if (rd_now && src.size() > 0) fifoData = src.pop_front();
    fifoEmpty = (src.size() == 0);
  endtask

  task automatic load(input int n, input int base);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(DW'(base + i));
    fifoEmpty = (src.size() == 0);
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    step();
    Rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [DW-1:0] got[$];
  int nrd;

  initial begin
    // Reset held three cycles with data available and EN high
    EN = 1'b1;
    outReady = 1'b1;
    load(1, 9);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk("rst_fifoRd", fifoRd, 0);
      chk("rst_outValid", outValid, 0);
      chk("rst_outData", outData, 0);
      chk("rst_rdCount", rdCount, 0);
      chk("rst_busy", busy, 0);
    end
    Rst = 1'b1;

    // Single word
    load(1, 5);
    #1 chk("single_rd", fifoRd, 1);
    step();
    #1;
    chk("single_rd_off", fifoRd, 0);
    chk("single_wait", outValid, 0);
    chk("single_busy", busy, 1);
    step();
    #1;
    chk("single_valid", outValid, 1);
    chk("single_data", outData, 4'h5);
    step();
    #1;
    chk("single_done", outValid, 0);
    chk("single_count", rdCount, 1);
    chk("single_idle", busy, 0);
    chk("single_empty_rd", fifoRd, 0);

    // Streaming with no gaps
    do_reset();
    load(4, 0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("stream_valid", outValid, (i >= 2 && i <= 5));
      if (i >= 2 && i <= 5) chk("stream_data", outData, i - 2);
      step();
    end
    #1 chk("stream_count", rdCount, 4);

    // Backpressure
    do_reset();
    outReady = 1'b0;
    load(4, 0);
    nrd = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (fifoRd) nrd++;
      if (i >= 2) begin
        chk("bp_valid", outValid, 1);
        chk("bp_hold", outData, 0);
      end
      step();
    end
    chk("bp_rd_pulses", nrd, 2);
    outReady = 1'b1;
    got.delete();
    for (int i = 0; i < 12 && got.size() < 4; i++) begin
      #1;
      if (outValid) got.push_back(outData);
      step();
    end
    chk("bp_words", got.size(), 4);
    foreach (got[k]) chk("bp_order", got[k], k);
    #1 chk("bp_count", rdCount, 4);

    // EN dropped after the first read
    do_reset();
    load(6, 7);
    got.delete();
    for (int i = 0; i < 20 && got.size() < 6; i++) begin
      if (i == 1) EN = 1'b0;
      if (i == 4) EN = 1'b1;
      #1;
      if (i == 0) chk("en_first_rd", fifoRd, 1);
      if (i >= 1 && i <= 3) chk("en_low_rd", fifoRd, 0);
      if (i == 2) chk("en_inflight_data", outData, 4'h7);
      if (outValid && outReady) got.push_back(outData);
      step();
    end
    chk("en_words", got.size(), 6);
    foreach (got[k]) chk("en_order", got[k], 7 + k);
    #1 chk("en_count", rdCount, 6);

    // Reset while a word is in flight
    do_reset();
    load(8, 1);
    for (int i = 0; i < 4; i++) step();
    outReady = 1'b0;
    #1;
    chk("mid_count", rdCount, 2);
    chk("mid_head", outData, 3);
    chk("mid_busy", busy, 1);
    chk("mid_nocredit", fifoRd, 0);
    Rst = 1'b0;
    #1 chk("mid_rst_rd", fifoRd, 0);
    step();
    #1;
    chk("mid_rst_valid", outValid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", rdCount, 0);
    Rst = 1'b1;
    outReady = 1'b1;
    got.delete();
    for (int i = 0; i < 10 && got.size() < 1; i++) begin
      #1;
      if (outValid) got.push_back(outData);
      step();
    end
    chk("mid_restart_words", got.size(), 1);
    if (got.size() > 0) chk("mid_restart_head", got[0], 5);

    // Counter wrap: 260 words delivered
    do_reset();
    load(260, 0);
    for (int i = 0; i < 270; i++) step();
    #1;
    chk("wrap_count", rdCount, 4);
    chk("wrap_idle", busy, 0);

    // Randomised traffic against the model
    do_reset();
    src.delete();
    for (int n = 0; n < 3000; n++) begin
      Rst = ($urandom_range(0, 199) != 0);
      EN = ($urandom_range(0, 9) != 0);
      outReady = ($urandom_range(0, 9) < 7);
      if ((n % 128) >= 20 && src.size() < 3 && $urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 6)) src.push_back(DW'($urandom));
      fifoEmpty = (src.size() == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
